sarray_store_unit: RTL and testbench

- Store-side drain stage directly downstream of the systolic array.
- Captures bottom-row result beats (valid/cnt/data) from the array, which has no backpressure, into a small FIFO.
- Converts each buffered beat into a write request on the array's store channel (valid/ready, addr, data); address = per-instruction base + (row cnt << ROW_SHIFT).
- Signals completion per store instruction and asserts an early stall so the array controller can hold new tmma issue before the FIFO overflows.

---
 rtl/sarray_store_unit.sv | 158 +++++++++++++++
 tb/tb_sarray_store_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sarray_store_unit.sv
// Store-side drain stage below the systolic array: buffers bottom-row beats and turns them into store writes.
// Optional row-order checking is enabled by defining SARRAY_STORE_ORDER_CHECK_EN (adds order_err_o).
module sarray_store_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_SHIFT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr_i,
  input  logic [CNT_WIDTH:0]    cfg_rows_i,
  input  logic                  bot_valid_i,
  input  logic [CNT_WIDTH-1:0]  bot_cnt_i,
  input  logic [DATA_WIDTH-1:0] bot_data_i,
  output logic                  stall_o,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  output logic [ADDR_WIDTH-1:0] aw_addr_o,
  output logic [DATA_WIDTH-1:0] aw_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef SARRAY_STORE_ORDER_CHECK_EN
  ,
  output logic                  order_err_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  typedef logic [PTR_W:0] ptr_t;
  localparam ptr_t                 PTR_ONE  = ptr_t'(1);
  localparam logic [CNT_WIDTH:0]   ROWS_ONE = (CNT_WIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CNT_WIDTH:0]    r_rows;
  logic [CNT_WIDTH:0]    r_wr_cnt;
  ptr_t                  r_wr_ptr, r_rd_ptr;
  ptr_t                  w_occ;
  logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic                  r_err;

  logic                  w_empty, w_full, w_pop;
  logic                  w_push_req, w_push, w_drop;
  logic                  w_cfg_take, w_last_pop, w_flush_err, w_order_err;
  logic [ADDR_WIDTH-1:0] w_push_addr;

  assign w_occ   = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  assign w_pop       = ~w_empty & aw_ready_i;
  assign w_push_req  = bot_valid_i && (r_state == S_ACTIVE);
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop      = bot_valid_i && !w_push;
  assign w_cfg_take  = (r_state == S_IDLE) && cfg_valid_i;
  assign w_last_pop  = (r_state == S_ACTIVE) && w_pop && (r_wr_cnt == r_rows - ROWS_ONE);
  // Anything still queued (or arriving) when the last row is written is surplus.
  assign w_flush_err = w_last_pop && ((w_occ != PTR_ONE) || w_push);
  assign w_push_addr = r_base + (ADDR_WIDTH'(bot_cnt_i) << ROW_SHIFT);

`ifdef SARRAY_STORE_ORDER_CHECK_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  logic [CNT_WIDTH-1:0] r_exp_cnt;

  assign w_order_err = w_push_req && (bot_cnt_i != r_exp_cnt);
  assign order_err_o = w_order_err;

  always_ff @(posedge clk) begin
    if (rst)             r_exp_cnt <= '0;
    else if (w_cfg_take) r_exp_cnt <= '0;
    else if (w_push)     r_exp_cnt <= r_exp_cnt + CNT_ONE;
  end
`else
  assign w_order_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output is given a default first so no path leaves a latch behind.
  always_comb begin
    w_state_nxt = r_state;
    cfg_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) w_state_nxt = (cfg_rows_i == '0) ? S_DONE : S_ACTIVE;
      end
      S_ACTIVE: begin
        busy_o = 1'b1;
        if (w_last_pop) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base   <= '0;
      r_rows   <= '0;
      r_wr_cnt <= '0;
    end else if (w_cfg_take) begin
      r_base   <= cfg_base_addr_i;
      r_rows   <= cfg_rows_i;
      r_wr_cnt <= '0;
    end else if ((r_state == S_ACTIVE) && w_pop) begin
      r_wr_cnt <= r_wr_cnt + ROWS_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_last_pop) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the head is masked to zero while empty, so stale entries never show.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr[PTR_W-1:0]] <= w_push_addr;
      r_mem_data[r_wr_ptr[PTR_W-1:0]] <= bot_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                     r_err <= 1'b0;
    else if (w_drop || w_flush_err || w_order_err) r_err <= 1'b1;
  end

  assign aw_valid_o = ~w_empty;
  assign aw_addr_o  = w_empty ? '0 : r_mem_addr[r_rd_ptr[PTR_W-1:0]];
  assign aw_data_o  = w_empty ? '0 : r_mem_data[r_rd_ptr[PTR_W-1:0]];
  assign stall_o    = (w_occ >= ptr_t'(FIFO_DEPTH - 1));
  assign err_o      = r_err;

endmodule

// File: tb/tb_sarray_store_unit.sv
// Self-checking bench for sarray_store_unit: directed scenarios plus randomized jobs against a queue-based model.
module tb_sarray_store_unit;
  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int CW    = 6;
  localparam int DEPTH = 4;
  localparam int RS    = 8;
  typedef logic [DW-1:0] word_t;

  logic          clk;
  logic          rst;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [AW-1:0] cfg_base_addr_i;
  logic [CW:0]   cfg_rows_i;
  logic          bot_valid_i;
  logic [CW-1:0] bot_cnt_i;
  logic [DW-1:0] bot_data_i;
  logic          stall_o;
  logic          aw_valid_o;
  logic          aw_ready_i;
  logic [AW-1:0] aw_addr_o;
  logic [DW-1:0] aw_data_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
`ifdef SARRAY_STORE_ORDER_CHECK_EN
  logic          order_err_o;
`endif

  sarray_store_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_DEPTH(DEPTH), .ROW_SHIFT(RS)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_base_addr_i(cfg_base_addr_i), .cfg_rows_i(cfg_rows_i),
    .bot_valid_i(bot_valid_i), .bot_cnt_i(bot_cnt_i), .bot_data_i(bot_data_i),
    .stall_o(stall_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .aw_addr_o(aw_addr_o), .aw_data_o(aw_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
`ifdef SARRAY_STORE_ORDER_CHECK_EN
    , .order_err_o(order_err_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: job phase (0 idle, 1 active, 2 done), queued writes, sticky error.
  int            m_phase;
  int            m_rows;
  int            m_wr;
  int            m_exp;
  logic [AW-1:0] m_base;
  logic          m_err;
  logic [AW-1:0] m_qa[$];
  word_t         m_qd[$];

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_rows = 0; m_wr = 0; m_exp = 0; m_base = '0; m_err = 1'b0;
    m_qa.delete(); m_qd.delete();
  endtask

  task automatic compare_outputs();
    logic [AW-1:0] ea;
    word_t         ed;
    ea = (m_qa.size() > 0) ? m_qa[0] : '0;
    ed = (m_qd.size() > 0) ? m_qd[0] : '0;
    check("cfg_ready", word_t'(cfg_ready_o), word_t'(m_phase == 0));
    check("busy",      word_t'(busy_o),      word_t'(m_phase == 1));
    check("done",      word_t'(done_o),      word_t'(m_phase == 2));
    check("aw_valid",  word_t'(aw_valid_o),  word_t'(m_qa.size() > 0));
    check("aw_addr",   word_t'(aw_addr_o),   word_t'(ea));
    check("aw_data",   aw_data_o,            ed);
    check("stall",     word_t'(stall_o),     word_t'(m_qa.size() >= DEPTH - 1));
    check("err",       word_t'(err_o),       word_t'(m_err));
`ifdef SARRAY_STORE_ORDER_CHECK_EN
    check("order_err", word_t'(order_err_o),
          word_t'(m_phase == 1 && bot_valid_i && (int'(bot_cnt_i) != (m_exp % 64))));
`endif
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit pop;
    pop = (m_qa.size() > 0) && aw_ready_i;
    case (m_phase)
      0: begin
        if (bot_valid_i) m_err = 1'b1;
        if (cfg_valid_i) begin
          m_base = cfg_base_addr_i; m_rows = int'(cfg_rows_i); m_wr = 0; m_exp = 0;
          m_phase = (cfg_rows_i == 0) ? 2 : 1;
        end
      end
      1: begin
        if (pop) begin
          void'(m_qa.pop_front()); void'(m_qd.pop_front()); m_wr++;
        end
        if (bot_valid_i) begin
`ifdef SARRAY_STORE_ORDER_CHECK_EN
          if (int'(bot_cnt_i) != (m_exp % 64)) m_err = 1'b1;
`endif
          if (m_qa.size() == DEPTH) m_err = 1'b1;
          else begin
            m_qa.push_back(m_base + (AW'(bot_cnt_i) << RS));
            m_qd.push_back(bot_data_i);
            m_exp++;
          end
        end
        if (pop && m_wr == m_rows) begin
          if (m_qa.size() != 0) m_err = 1'b1;
          m_qa.delete(); m_qd.delete();
          m_phase = 2;
        end
      end
      default: begin
        if (bot_valid_i) m_err = 1'b1;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic cyc();
    #1;
    compare_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cfg_valid_i = 1'b0; cfg_base_addr_i = '0; cfg_rows_i = '0;
    bot_valid_i = 1'b0; bot_cnt_i = '0; bot_data_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic beat(input int cnt);
    bot_valid_i = 1'b1;
    bot_cnt_i   = CW'(cnt);
    for (int k = 0; k < DW / 32; k++) bot_data_i[k*32 +: 32] = $urandom();
  endtask

  task automatic start_job(input logic [AW-1:0] base, input int rows);
    cfg_valid_i = 1'b1; cfg_base_addr_i = base; cfg_rows_i = (CW+1)'(rows);
    cyc();
    idle_inputs();
  endtask

  initial begin
    int rows;
    int sent;
    aw_ready_i = 1'b1;
    do_reset();
    cyc();

    // Streaming job with the store channel always ready.
    start_job(64'h1000, 4);
    for (int i = 0; i < 4; i++) begin
      beat(i);
      cyc();
      check("t1_head_addr", word_t'(aw_addr_o), word_t'(64'h1000 + 64'(i) * 64'h100));
    end
    idle_inputs();
    cyc();
    check("t1_done", word_t'(done_o), word_t'(1));
    cyc();
    check("t1_err", word_t'(err_o), word_t'(0));

    // Backpressured job: stall, overflow drop, drain after ready rises.
    aw_ready_i = 1'b0;
    start_job(64'h1000, 4);
    for (int i = 0; i < 5; i++) begin
      beat(i);
      cyc();
      if (i == 2) check("t2_stall", word_t'(stall_o), word_t'(1));
    end
    check("t2_err", word_t'(err_o), word_t'(1));
    idle_inputs();
    cyc();
    aw_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    check("t2_idle", word_t'(cfg_ready_o), word_t'(1));

    // Push into a full FIFO in the same cycle as a handshake.
    do_reset();
    aw_ready_i = 1'b0;
    start_job(64'h2000, 8);
    for (int i = 0; i < 4; i++) begin
      beat(i);
      cyc();
    end
    beat(4);
    aw_ready_i = 1'b1;
    cyc();
    check("t3_stall_full", word_t'(stall_o), word_t'(1));
    check("t3_no_drop", word_t'(err_o), word_t'(0));
    for (int i = 5; i < 8; i++) begin
      beat(i);
      cyc();
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) cyc();
    check("t3_err_end", word_t'(err_o), word_t'(0));

    // Zero-row job, then a beat while idle.
    do_reset();
    start_job(64'h0, 0);
    check("t4_done", word_t'(done_o), word_t'(1));
    check("t4_no_aw", word_t'(aw_valid_o), word_t'(0));
    cyc();
    check("t4_done_off", word_t'(done_o), word_t'(0));
    beat(3);
    cyc();
    idle_inputs();
    check("t4_idle_err", word_t'(err_o), word_t'(1));
    cyc();

    // Address wrap, then reset with entries queued.
    do_reset();
    aw_ready_i = 1'b0;
    start_job(64'hFFFF_FFFF_FFFF_FF00, 4);
    beat(1);
    cyc();
    check("t5_wrap_addr", word_t'(aw_addr_o), word_t'(0));
    beat(2);
    cyc();
    do_reset();
    check("t5_rst_awv", word_t'(aw_valid_o), word_t'(0));
    check("t5_rst_ready", word_t'(cfg_ready_o), word_t'(1));
    cyc();

`ifdef SARRAY_STORE_ORDER_CHECK_EN
    // Out-of-order row index.
    do_reset();
    aw_ready_i = 1'b1;
    start_job(64'h3000, 2);
    beat(0);
    cyc();
    beat(2);
    #1;
    check("t6_order_pulse", word_t'(order_err_o), word_t'(1));
    cyc();
    idle_inputs();
    check("t6_second_row", word_t'(aw_addr_o), word_t'(64'h3200));
    cyc();
    check("t6_err", word_t'(err_o), word_t'(1));
    cyc();
`endif

    // Randomized jobs: random base, rows, beat timing, readiness and occasional bad beats.
    for (int j = 0; j < 20; j++) begin
      do_reset();
      aw_ready_i = 1'b1;
      rows = $urandom_range(1, 6);
      start_job({$urandom(), $urandom()}, rows);
      sent = 0;
      for (int c = 0; c < 3 * rows + 10; c++) begin
        aw_ready_i = ($urandom_range(0, 9) < 7);
        if (sent < rows + 1 && $urandom_range(0, 9) < 6) begin
          beat(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : sent);
          sent++;
        end else begin
          idle_inputs();
        end
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
